dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port of dual_port_BRAM_memory_subsystem between two requesters: port 0 is the core's data path, port 1 is a DMA/coprocessor master (e.g. cipher key/pt/ct mover).
- Arbitrates with bounded round-robin and tracks outstanding reads in an in-order route FIFO, so each read response returns only to its issuer.
- Sits between the requesters and the memory subsystem's d_mem_* interface.

---
 rtl/dmem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the shared data-memory port: bounded round-robin grant plus an
// in-order route FIFO that steers each read response back to its issuer. Optional DMEM_ARB_PERF_EN adds stall counters.
module dmem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int ROUTE_DEPTH  = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                rq_read,
  input  logic [1:0]                rq_write,
  input  logic [DATA_WIDTH/8-1:0]   rq0_byte_en,
  input  logic [DATA_WIDTH/8-1:0]   rq1_byte_en,
  input  logic [ADDRESS_BITS-1:0]   rq0_address,
  input  logic [ADDRESS_BITS-1:0]   rq1_address,
  input  logic [DATA_WIDTH-1:0]     rq0_wdata,
  input  logic [DATA_WIDTH-1:0]     rq1_wdata,
  output logic [1:0]                rq_ack,
  output logic [DATA_WIDTH-1:0]     rs0_data,
  output logic [DATA_WIDTH-1:0]     rs1_data,
  output logic [ADDRESS_BITS-1:0]   rs0_address,
  output logic [ADDRESS_BITS-1:0]   rs1_address,
  output logic [1:0]                rs_valid,
  output logic                      d_mem_read,
  output logic                      d_mem_write,
  output logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  output logic [DATA_WIDTH-1:0]     d_mem_data_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_out,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  input  logic                      d_mem_valid,
  input  logic                      d_mem_ready,
  output logic                      route_err,
  output logic [31:0]               stall0_cnt,
  output logic [31:0]               stall1_cnt
);
  localparam int PW = $clog2(ROUTE_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);

  logic                    run_q;
  logic                    owner_q, owner_d;
  logic [BW-1:0]           burst_q, burst_d;
  logic [ROUTE_DEPTH-1:0]  fifo_q, fifo_d;
  logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]             cnt_q, cnt_d;
  logic [1:0]              rs_valid_q, rs_valid_d;
  logic [1:0][DATA_WIDTH-1:0]   rs_data_q, rs_data_d;
  logic [1:0][ADDRESS_BITS-1:0] rs_addr_q, rs_addr_d;
  logic                    route_err_q, route_err_d;

  logic [1:0] elig;
  logic       empty, full, pop, push, gnt_vld, gnt, gnt_rd, accept, head;

  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == (PW+1)'(ROUTE_DEPTH));
    pop   = d_mem_valid && !empty;
    head  = fifo_q[rp_q];
    // run_q keeps every combinational output at 0 while reset is asserted
    for (int p = 0; p < 2; p++)
      elig[p] = run_q && (rq_read[p] || rq_write[p]) && (!rq_read[p] || !full || pop);
    gnt_vld = |elig;
    if (&elig) gnt = (burst_q < BW'(MAX_BURST)) ? owner_q : !owner_q;
    else       gnt = elig[1];
    accept = gnt_vld && d_mem_ready;
    rq_ack = 2'b00;
    if (accept) rq_ack[gnt] = 1'b1;

    gnt_rd           = rq_read[gnt];
    d_mem_read       = gnt_vld && gnt_rd;
    d_mem_write      = gnt_vld && !gnt_rd;
    d_mem_byte_en    = '0;
    d_mem_address_in = '0;
    d_mem_data_in    = '0;
    if (gnt_vld) begin
      d_mem_byte_en    = gnt ? rq1_byte_en : rq0_byte_en;
      d_mem_address_in = gnt ? rq1_address : rq0_address;
      d_mem_data_in    = gnt ? rq1_wdata   : rq0_wdata;
    end
    push = accept && gnt_rd;

    owner_d = owner_q;
    burst_d = burst_q;
    if (accept) begin
      if (gnt == owner_q) begin
        if (burst_q < BW'(MAX_BURST)) burst_d = burst_q + 1'b1;
      end else begin
        owner_d = gnt;
        burst_d = BW'(1);
      end
    end

    fifo_d = fifo_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (push) begin
      fifo_d[wp_q] = gnt;
      wp_d         = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    rs_valid_d = 2'b00;
    rs_data_d  = '0;
    rs_addr_d  = '0;
    if (pop) begin
      rs_valid_d[head] = 1'b1;
      rs_data_d[head]  = d_mem_data_out;
      rs_addr_d[head]  = d_mem_address_out;
    end
    route_err_d = route_err_q || (d_mem_valid && empty);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q       <= 1'b0;
      owner_q     <= 1'b0;
      burst_q     <= '0;
      fifo_q      <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      rs_valid_q  <= '0;
      rs_data_q   <= '0;
      rs_addr_q   <= '0;
      route_err_q <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      fifo_q      <= fifo_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      rs_valid_q  <= rs_valid_d;
      rs_data_q   <= rs_data_d;
      rs_addr_q   <= rs_addr_d;
      route_err_q <= route_err_d;
    end
  end

  assign rs_valid    = rs_valid_q;
  assign rs0_data    = rs_data_q[0];
  assign rs1_data    = rs_data_q[1];
  assign rs0_address = rs_addr_q[0];
  assign rs1_address = rs_addr_q[1];
  assign route_err   = route_err_q;

`ifdef DMEM_ARB_PERF_EN
  logic [1:0][31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    for (int p = 0; p < 2; p++)
      if (elig[p] && !rq_ack[p] && (stall_q[p] != '1)) stall_d[p] = stall_q[p] + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall0_cnt = stall_q[0];
  assign stall1_cnt = stall_q[1];
`else
  assign stall0_cnt = '0;
  assign stall1_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a vector table for routing/latency plus hand sequences
// for contention, FIFO full, backpressure, route error and asynchronous reset.
module tb_dmem_port_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  rq_read = '0, rq_write = '0;
  logic [3:0]  rq0_byte_en = 4'h3, rq1_byte_en = 4'hC;
  logic [31:0] rq0_address = '0, rq1_address = '0;
  logic [31:0] rq0_wdata = 32'h1111_0000, rq1_wdata = 32'h2222_0000;
  logic [1:0]  rq_ack, rs_valid;
  logic [31:0] rs0_data, rs1_data, rs0_address, rs1_address;
  logic        d_mem_read, d_mem_write, route_err;
  logic [3:0]  d_mem_byte_en;
  logic [31:0] d_mem_address_in, d_mem_data_in;
  logic [31:0] d_mem_data_out = '0, d_mem_address_out = '0;
  logic        d_mem_valid = 1'b0, d_mem_ready = 1'b0;
  logic [31:0] stall0_cnt, stall1_cnt;

  int checks = 0;
  int failures = 0;

  dmem_port_arbiter dut (
    .clock(clock), .reset(reset), .rq_read(rq_read), .rq_write(rq_write),
    .rq0_byte_en(rq0_byte_en), .rq1_byte_en(rq1_byte_en),
    .rq0_address(rq0_address), .rq1_address(rq1_address),
    .rq0_wdata(rq0_wdata), .rq1_wdata(rq1_wdata), .rq_ack(rq_ack),
    .rs0_data(rs0_data), .rs1_data(rs1_data), .rs0_address(rs0_address),
    .rs1_address(rs1_address), .rs_valid(rs_valid), .d_mem_read(d_mem_read),
    .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
    .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in),
    .d_mem_data_out(d_mem_data_out), .d_mem_address_out(d_mem_address_out),
    .d_mem_valid(d_mem_valid), .d_mem_ready(d_mem_ready), .route_err(route_err),
    .stall0_cnt(stall0_cnt), .stall1_cnt(stall1_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a * 32'd3 + 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a0,
                        input logic [31:0] a1, input logic rdy, input logic vld,
                        input logic [31:0] aout);
    @(negedge clock);
    rq_read = rd; rq_write = wr; rq0_address = a0; rq1_address = a1;
    d_mem_ready = rdy; d_mem_valid = vld;
    d_mem_address_out = vld ? aout : 32'h0;
    d_mem_data_out    = vld ? mw(aout) : 32'h0;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rq_read = '0; rq_write = '0; d_mem_valid = 1'b0; d_mem_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] a0, a1;
    logic        vld;
    logic [31:0] aout;
    logic [1:0]  e_ack;
    logic        e_mrd, e_mwr;
    logic [31:0] e_maddr;
    logic [1:0]  e_rsv;
    logic [31:0] e_rs0a, e_rs1a;
  } vec_t;

  vec_t vt[12];

  initial begin
    // rd wr a0 a1 vld aout | ack mrd mwr maddr | rsv rs0a rs1a (data checked as mw(addr) or 0)
    vt[0]  = '{2'b01, 2'b00, 32'h06, 32'h0,  1'b0, 32'h0,  2'b01, 1'b1, 1'b0, 32'h06, 2'b00, 32'h0,  32'h0};
    vt[1]  = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 32'h06, 2'b00, 1'b0, 1'b0, 32'h0,  2'b01, 32'h06, 32'h0};
    vt[2]  = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 32'h0,  32'h0};
    vt[3]  = '{2'b01, 2'b00, 32'h02, 32'h0,  1'b0, 32'h0,  2'b01, 1'b1, 1'b0, 32'h02, 2'b00, 32'h0,  32'h0};
    vt[4]  = '{2'b10, 2'b00, 32'h0,  32'h0a, 1'b0, 32'h0,  2'b10, 1'b1, 1'b0, 32'h0a, 2'b00, 32'h0,  32'h0};
    vt[5]  = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 32'h0,  32'h0};
    vt[6]  = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 32'h02, 2'b00, 1'b0, 1'b0, 32'h0,  2'b01, 32'h02, 32'h0};
    vt[7]  = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 32'h0a, 2'b00, 1'b0, 1'b0, 32'h0,  2'b10, 32'h0,  32'h0a};
    vt[8]  = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 32'h0,  32'h0};
    vt[9]  = '{2'b00, 2'b01, 32'h40, 32'h0,  1'b0, 32'h0,  2'b01, 1'b0, 1'b1, 32'h40, 2'b00, 32'h0,  32'h0};
    vt[10] = '{2'b10, 2'b10, 32'h0,  32'h44, 1'b0, 32'h0,  2'b10, 1'b1, 1'b0, 32'h44, 2'b00, 32'h0,  32'h0};
    vt[11] = '{2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 32'h44, 2'b00, 1'b0, 1'b0, 32'h0,  2'b10, 32'h0,  32'h44};

    #1;
    chk("reset_ack", 32'(rq_ack), 32'h0);
    chk("reset_rsv", 32'(rs_valid), 32'h0);
    chk("reset_mem_rw", 32'({d_mem_read, d_mem_write}), 32'h0);
    chk("reset_maddr", d_mem_address_in, 32'h0);
    chk("reset_route_err", 32'(route_err), 32'h0);
    chk("reset_stall0", stall0_cnt, 32'h0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].rd, vt[i].wr, vt[i].a0, vt[i].a1, 1'b1, vt[i].vld, vt[i].aout);
      chk($sformatf("v%0d_ack", i), 32'(rq_ack), 32'(vt[i].e_ack));
      chk($sformatf("v%0d_mrd", i), 32'(d_mem_read), 32'(vt[i].e_mrd));
      chk($sformatf("v%0d_mwr", i), 32'(d_mem_write), 32'(vt[i].e_mwr));
      chk($sformatf("v%0d_maddr", i), d_mem_address_in, vt[i].e_maddr);
      edge_step();
      chk($sformatf("v%0d_rsv", i), 32'(rs_valid), 32'(vt[i].e_rsv));
      chk($sformatf("v%0d_rs0a", i), rs0_address, vt[i].e_rs0a);
      chk($sformatf("v%0d_rs1a", i), rs1_address, vt[i].e_rs1a);
      chk($sformatf("v%0d_rs0d", i), rs0_data, vt[i].e_rsv[0] ? mw(vt[i].e_rs0a) : 32'h0);
      chk($sformatf("v%0d_rs1d", i), rs1_data, vt[i].e_rsv[1] ? mw(vt[i].e_rs1a) : 32'h0);
    end

    // contention: continuous writes from both ports
    do_reset();
    for (int i = 0; i < 24; i++) begin
      logic p1;
      p1 = (i >= 8 && i < 16);
      set_in(2'b00, 2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
      chk($sformatf("cont%0d_ack", i), 32'(rq_ack), p1 ? 32'h2 : 32'h1);
      chk($sformatf("cont%0d_wdata", i), d_mem_data_in, p1 ? 32'h2222_0000 : 32'h1111_0000);
      chk($sformatf("cont%0d_be", i), 32'(d_mem_byte_en), p1 ? 32'hC : 32'h3);
      edge_step();
    end
`ifdef DMEM_ARB_PERF_EN
    chk("stall0_after_cont", stall0_cnt, 32'd8);
    chk("stall1_after_cont", stall1_cnt, 32'd16);
`else
    chk("stall0_after_cont", stall0_cnt, 32'd0);
    chk("stall1_after_cont", stall1_cnt, 32'd0);
`endif

    // FIFO full: four outstanding reads, a fifth waits for the pop cycle
    do_reset();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'h10 + 32'(k);
      if (k % 2 == 0) set_in(2'b01, 2'b00, a, 32'h0, 1'b1, 1'b0, 32'h0);
      else            set_in(2'b10, 2'b00, 32'h0, a, 1'b1, 1'b0, 32'h0);
      chk($sformatf("fill%0d_ack", k), 32'(rq_ack), (k % 2 == 0) ? 32'h1 : 32'h2);
      edge_step();
    end
    for (int k = 0; k < 2; k++) begin
      set_in(2'b01, 2'b00, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("full%0d_ack", k), 32'(rq_ack), 32'h0);
      chk($sformatf("full%0d_mrd", k), 32'(d_mem_read), 32'h0);
      edge_step();
    end
    set_in(2'b01, 2'b00, 32'h20, 32'h0, 1'b1, 1'b1, 32'h10);
    chk("full_pop_ack", 32'(rq_ack), 32'h1);
    chk("full_pop_mrd", 32'(d_mem_read), 32'h1);
    edge_step();
    chk("full_pop_rsv", 32'(rs_valid), 32'h1);
    chk("full_pop_rs0d", rs0_data, mw(32'h10));
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      logic        p;
      a = (k == 3) ? 32'h20 : 32'h11 + 32'(k);
      p = (k % 2 == 0);
      set_in(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, a);
      edge_step();
      chk($sformatf("drain%0d_rsv", k), 32'(rs_valid), p ? 32'h2 : 32'h1);
      chk($sformatf("drain%0d_data", k), p ? rs1_data : rs0_data, mw(a));
      chk($sformatf("drain%0d_addr", k), p ? rs1_address : rs0_address, a);
    end
    set_in(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h99);
    edge_step();
    chk("empty_valid_rsv", 32'(rs_valid), 32'h0);
    chk("empty_valid_err", 32'(route_err), 32'h1);
    set_in(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    edge_step();
    chk("err_sticky", 32'(route_err), 32'h1);

    // asynchronous reset mid-burst with a read outstanding
    set_in(2'b01, 2'b00, 32'h30, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("pre_rst_read_ack", 32'(rq_ack), 32'h1);
    edge_step();
    for (int k = 0; k < 3; k++) begin
      set_in(2'b00, 2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
      edge_step();
    end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_ack", 32'(rq_ack), 32'h0);
    chk("arst_mem_rw", 32'({d_mem_read, d_mem_write}), 32'h0);
    chk("arst_maddr", d_mem_address_in, 32'h0);
    chk("arst_mdata", d_mem_data_in, 32'h0);
    chk("arst_route_err", 32'(route_err), 32'h0);
    chk("arst_rsv", 32'(rs_valid), 32'h0);
    rq_read = '0; rq_write = '0;
    @(negedge clock);
    reset = 1'b1;
    set_in(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h30);
    edge_step();
    chk("late_valid_rsv", 32'(rs_valid), 32'h0);
    chk("late_valid_err", 32'(route_err), 32'h1);

    // backpressure: owner is port 1, ready low for five cycles
    do_reset();
    set_in(2'b00, 2'b10, 32'h0, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("bp_own_ack", 32'(rq_ack), 32'h2);
    edge_step();
    for (int k = 0; k < 5; k++) begin
      set_in(2'b00, 2'b11, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0);
      chk($sformatf("bp%0d_ack", k), 32'(rq_ack), 32'h0);
      chk($sformatf("bp%0d_maddr", k), d_mem_address_in, 32'h200);
      edge_step();
    end
    set_in(2'b00, 2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("bp_release_ack", 32'(rq_ack), 32'h2);
    edge_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
